// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared types and widths for the NCO transmit-chain control blocks
package dsm_pkg;

  localparam int NCO_STEP_W = 32;

  typedef enum logic [1:0] {
    SINGLE   = 2'd0,
    SAWTOOTH = 2'd1,
    TRIANGLE = 2'd2
  } sweep_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - frequency-sweep sequencer feeding NCO step words over a stream interface
module nco_sweep_ctrl
  import dsm_pkg::*;
#(
  parameter int ACC_FRAC_WIDTH = 24,
  parameter int ACC_INT_WIDTH  = 8,
  parameter int DWELL_WIDTH    = 16,
  localparam int SW            = ACC_FRAC_WIDTH + ACC_INT_WIDTH
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [SW-1:0]          cfg_start_step,
  input  logic [SW-1:0]          cfg_stop_step,
  input  logic [SW-1:0]          cfg_inc,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [SW-1:0]          m_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic                   busy,
  output logic                   sweep_done
);

  sweep_state_e           state_q, state_d;
  logic [SW-1:0]          cur_q, cur_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [SW-1:0]          start_q, stop_q, inc_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [1:0]             mode_q;
  logic                   done_q, done_d;
  logic                   latch_cfg;

  logic                   active, beat, last_beat, single_pt, end_of_sweep;
  logic [SW:0]            up_sum, dn_diff;
  logic [SW-1:0]          up_clamp, dn_clamp;

  // At an endpoint cur equals stop (UP) or start (DOWN), so the same two
  // clamped expressions also produce the triangle turnaround points.
  assign up_sum   = {1'b0, cur_q} + {1'b0, inc_q};
  assign dn_diff  = {1'b0, cur_q} - {1'b0, inc_q};
  assign up_clamp = (up_sum[SW] || (up_sum[SW-1:0] > stop_q)) ? stop_q : up_sum[SW-1:0];
  assign dn_clamp = (dn_diff[SW] || (dn_diff[SW-1:0] < start_q)) ? start_q : dn_diff[SW-1:0];

  assign active       = (state_q != IDLE);
  assign beat         = active && m_axis_data_tready;
  assign last_beat    = beat && (dwell_cnt_q == dwell_q);
  assign single_pt    = (start_q >= stop_q);
  assign end_of_sweep = (state_q == UP) ? (single_pt || cur_q == stop_q) : (cur_q == start_q);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    dwell_cnt_d = dwell_cnt_q;
    done_d      = 1'b0;
    latch_cfg   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_cfg   = 1'b1;
          state_d     = UP;
          cur_d       = cfg_start_step;
          dwell_cnt_d = '0;
        end
      end
      default: begin
        if (beat) dwell_cnt_d = last_beat ? '0 : dwell_cnt_q + 1'b1;
        // A zero increment parks on the start word until aborted.
        if (last_beat && (inc_q != '0)) begin
          if (end_of_sweep) begin
            case (mode_q)
              SAWTOOTH: begin
                state_d = UP;
                cur_d   = start_q;
              end
              TRIANGLE: begin
                if (single_pt) begin
                  state_d = UP;
                  cur_d   = start_q;
                end else if (state_q == UP) begin
                  state_d = DOWN;
                  cur_d   = dn_clamp;
                end else begin
                  state_d = UP;
                  cur_d   = up_clamp;
                end
              end
              default: begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            cur_d = (state_q == UP) ? up_clamp : dn_clamp;
          end
        end
      end
    endcase
    if (abort) begin
      state_d     = IDLE;
      dwell_cnt_d = '0;
      done_d      = 1'b0;
      latch_cfg   = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
      start_q     <= '0;
      stop_q      <= '0;
      inc_q       <= '0;
      dwell_q     <= '0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      dwell_cnt_q <= dwell_cnt_d;
      done_q      <= done_d;
      if (latch_cfg) begin
        start_q <= cfg_start_step;
        stop_q  <= cfg_stop_step;
        inc_q   <= cfg_inc;
        dwell_q <= cfg_dwell;
        mode_q  <= cfg_mode;
      end
    end
  end

  assign m_axis_data_tdata  = cur_q;
  assign m_axis_data_tvalid = active;
  assign busy               = active;
  assign sweep_done         = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - directed self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] cfg_start_step = '0;
  logic [31:0] cfg_stop_step = '0;
  logic [31:0] cfg_inc = '0;
  logic [15:0] cfg_dwell = '0;
  logic [1:0]  cfg_mode = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        busy;
  logic        sweep_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  nco_sweep_ctrl dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_start_step     (cfg_start_step),
    .cfg_stop_step      (cfg_stop_step),
    .cfg_inc            (cfg_inc),
    .cfg_dwell          (cfg_dwell),
    .cfg_mode           (cfg_mode),
    .start              (start),
    .abort              (abort),
    .m_axis_data_tdata  (tdata),
    .m_axis_data_tvalid (tvalid),
    .m_axis_data_tready (tready),
    .busy               (busy),
    .sweep_done         (sweep_done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                           input logic [15:0] dw, input logic [1:0] mode);
    cfg_start_step = s;
    cfg_stop_step  = e;
    cfg_inc        = inc;
    cfg_dwell      = dw;
    cfg_mode       = mode;
  endtask

  // Ends on the negedge of the first cycle the sweep is visible.
  task automatic pulse_start();
    @(negedge aclk);
    tready = 1'b0;
    start  = 1'b1;
    @(negedge aclk);
    start  = 1'b0;
  endtask

  task automatic pulse_abort();
    abort  = 1'b1;
    tready = 1'b0;
    @(negedge aclk);
    abort  = 1'b0;
  endtask

  // Expects every point in exp_q for dwell+1 accepted beats each; called on a negedge.
  task automatic run_points(input int dwell, input int duty);
    int beats;
    int cyc;
    foreach (exp_q[p]) begin
      beats = 0;
      cyc   = 0;
      while (beats < dwell + 1 && cyc < 400) begin
        tready = ($urandom_range(99) < duty);
        check("tvalid", tvalid, 1);
        check("tdata", tdata, exp_q[p]);
        if (tready) beats++;
        cyc++;
        @(negedge aclk);
      end
      if (beats < dwell + 1) check("point_timeout", beats, dwell + 1);
    end
    tready = 1'b0;
  endtask

  task automatic check_done();
    check("end_tvalid", tvalid, 0);
    check("end_busy", busy, 0);
    check("end_done", sweep_done, 1);
    @(negedge aclk);
    check("done_pulse_width", sweep_done, 0);
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);
    arst_n = 1'b1;

    // single sweep, 4 points of 3 beats
    configure(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd2, 2'd0);
    exp_q = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
    pulse_start();
    check("start_busy", busy, 1);
    run_points(2, 100);
    check_done();

    // clamp to stop
    configure(32'h10, 32'h25, 32'h10, 16'd0, 2'd0);
    exp_q = '{32'h10, 32'h20, 32'h25};
    pulse_start();
    run_points(0, 100);
    check_done();

    // carry clamp
    configure(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2'd3);
    exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
    pulse_start();
    run_points(0, 100);
    check_done();

    // triangle, endpoints not repeated
    configure(32'd1, 32'd3, 32'd1, 16'd0, 2'd2);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd1, 32'd2, 32'd3, 32'd2, 32'd1};
    pulse_start();
    run_points(0, 100);
    check("tri_busy", busy, 1);
    check("tri_next", tdata, 32'd2);
    pulse_abort();
    check("tri_abort_tvalid", tvalid, 0);

    // backpressure at 30% duty, same sequence as full-rate
    configure(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd2, 2'd0);
    exp_q = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000};
    pulse_start();
    run_points(2, 30);
    check_done();

    // abort with simultaneous start on 2nd beat of point 2
    exp_q = '{32'h0100_0000};
    pulse_start();
    run_points(2, 100);
    tready = 1'b1;
    check("ab_p2_b1", tdata, 32'h0200_0000);
    @(negedge aclk);
    check("ab_p2_b2", tdata, 32'h0200_0000);
    abort = 1'b1;
    start = 1'b1;
    @(negedge aclk);
    abort  = 1'b0;
    start  = 1'b0;
    tready = 1'b0;
    check("ab_tvalid", tvalid, 0);
    check("ab_busy", busy, 0);
    check("ab_done", sweep_done, 0);
    @(negedge aclk);
    check("ab_idle_busy", busy, 0);
    check("ab_idle_done", sweep_done, 0);
    pulse_start();
    check("restart_tdata", tdata, 32'h0100_0000);
    pulse_abort();

    // asynchronous reset mid-sweep
    pulse_start();
    tready = 1'b1;
    repeat (4) @(negedge aclk);
    #2 arst_n = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tdata", tdata, 0);
    check("arst_busy", busy, 0);
    check("arst_done", sweep_done, 0);
    @(negedge aclk);
    arst_n = 1'b1;
    tready = 1'b0;
    repeat (3) @(negedge aclk);
    check("post_rst_busy", busy, 0);

    // sawtooth wrap, config changes while busy ignored
    configure(32'd0, 32'd2, 32'd1, 16'd1, 2'd1);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
    pulse_start();
    configure(32'd7, 32'd9, 32'd3, 16'd0, 2'd0);
    run_points(1, 100);
    pulse_abort();

    // sawtooth single point start == stop holds forever
    configure(32'd5, 32'd5, 32'd1, 16'd0, 2'd1);
    exp_q = {};
    for (int i = 0; i < 20; i++) exp_q.push_back(32'd5);
    pulse_start();
    run_points(0, 100);
    check("hold_busy", busy, 1);
    pulse_abort();
    check("hold_abort_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Programmable frequency-sweep sequencer that drives the `nco_step` AXI-stream input of the unsigned NCO (`unco`) at the head of the NCO → MASH 1-1 → mod2 → upconverter transmit chain. It emits a sequence of NCO phase-step words from a start value to a stop value. Each step word is held for a programmable number of accepted NCO samples, so the chain can be characterised across frequency without software pacing. Single-shot, sawtooth-repeat and triangle sweeps are supported.

## Interface
- `ACC_FRAC_WIDTH`, 24, fractional bits of the NCO step word.
- `ACC_INT_WIDTH`, 8, integer bits of the NCO step word; `SW = ACC_FRAC_WIDTH + ACC_INT_WIDTH`.
- `DWELL_WIDTH`, 16, width of the dwell counter.

Ports:
- `aclk` in 1: the only clock.
- `arst_n` in 1: asynchronous, active-low reset.
- `cfg_start_step` in SW: first step word (unsigned).
- `cfg_stop_step` in SW: last step word (unsigned).
- `cfg_inc` in SW: step increment between points.
- `cfg_dwell` in DWELL_WIDTH: accepted beats per point, minus 1.
- `cfg_mode` in 2: sweep mode. 0 = single, 1 = sawtooth repeat, 2 = triangle, 3 = behaves as 0.
- `start` in 1: one-cycle pulse that begins a sweep.
- `abort` in 1: one-cycle pulse that terminates the sweep.
- `m_axis_data_tdata` out SW: current step word.
- `m_axis_data_tvalid` out 1: step word valid.
- `m_axis_data_tready` in 1: NCO accepts a beat.
- `busy` out 1: a sweep is in progress.
- `sweep_done` out 1: one-cycle pulse at the end of a single sweep.

## Operation
- States:
  - `IDLE`: tvalid = 0, busy = 0.
  - `UP`: stepping toward the stop word.
  - `DOWN`: stepping toward the start word (triangle mode only).
- `start` in `IDLE`:
  - Latches all `cfg_*` inputs into shadow registers.
  - Sets `cur = cfg_start_step`, `dwell_cnt = 0`, and enters `UP`.
- `cfg_*` changes while busy have no effect.
- In `UP` and `DOWN`:
  - tvalid = 1 and tdata = `cur`.
  - Every beat (tvalid & tready) increments `dwell_cnt`.
  - When a beat occurs with `dwell_cnt == dwell`, the point is complete: `dwell_cnt` clears and the next point is computed.
- Next point in `UP`:
  - `nxt = cur + inc`, computed at SW+1 bits.
  - If the carry is set or `nxt > stop`, `nxt = stop`.
  - If `cur == stop`, this is end-of-sweep.
- Next point in `DOWN`:
  - `nxt = cur - inc`.
  - If it borrows or `nxt < start`, `nxt = start`.
  - If `cur == start`, this is end-of-sweep.
- End-of-sweep by mode:
  - Mode 0/3: go to `IDLE`, pulse `sweep_done`.
  - Mode 1: `cur = start`, stay in `UP`.
  - Mode 2: from `UP` go to `DOWN` with `nxt = stop - inc` (clamped); from `DOWN` go to `UP` with `nxt = start + inc` (clamped). The endpoint is not repeated.
- Degenerate cases:
  - `start >= stop`: a single point at `start` only. End-of-sweep occurs after its dwell. In modes 1 and 2 that point repeats indefinitely.
  - `inc == 0`: holds `start` indefinitely, in any mode, until `abort`.
- `abort` in any state: next state is `IDLE`, tvalid falls next cycle, `sweep_done` is not pulsed. This intentionally breaks the AXI rule that tvalid must not drop without a handshake; the NCO tolerates it.
- `abort` takes priority over `start` and over end-of-sweep in the same cycle.
- `start` while busy is ignored.

## Timing
- Reset: tvalid = 0, tdata = 0, busy = 0, sweep_done = 0, state `IDLE`, counters 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` sampled at edge N: busy = 1, tvalid = 1, tdata = start word from cycle N+1.
- Point advance: the completing beat at edge K gives new tdata from cycle K+1. tvalid stays high with no bubble, so throughput is one beat per cycle while tready = 1.
- tdata is stable whenever tvalid = 1 and tready = 0.
- Mode 0 end: after the final beat at edge K, in cycle K+1 tvalid = 0, busy = 0 and sweep_done = 1 for exactly that cycle.
- tready low stalls `dwell_cnt` indefinitely; there is no timeout.
- Reset asserted mid-sweep forces the reset values asynchronously. After release the block waits in `IDLE` for `start`.

## Structure
- Shared package `dsm_pkg`:
  - `sweep_mode_e` (SINGLE, SAWTOOTH, TRIANGLE).
  - `sweep_state_e` (IDLE, UP, DOWN).
  - `NCO_STEP_W` localparam (32).
- Single module; no sub-module. The clamped add/subtract is two inline SW+1-bit expressions feeding one next-state block.

## Test plan
- Mode 0, start = 0x0100_0000, stop = 0x0400_0000, inc = 0x0100_0000, dwell = 2, tready = 1 → points 0x01, 0x02, 0x03, 0x04 (×2^24), each for 3 beats. 12 beats total, then sweep_done for 1 cycle and tvalid = 0.
- Clamp: start = 0x10, stop = 0x25, inc = 0x10, dwell = 0 → 0x10, 0x20, 0x25, then done. Repeat with start = 0xFFFF_FFF0, stop = 0xFFFF_FFFF, inc = 0x20 → carry clamps to 0xFFFF_FFFF.
- Mode 2, start = 1, stop = 3, inc = 1, dwell = 0 → 1, 2, 3, 2, 1, 2, 3, … with no repeated endpoints; `busy` stays 1.
- Backpressure: random tready at 30% duty → tdata stable while stalled, exactly (dwell+1) beats per point, sequence identical to the tready = 1 case.
- `abort` on the 2nd beat of point 2, with `start` pulsed in the same cycle → tvalid = 0 next cycle, no sweep_done, state `IDLE`. A later `start` restarts from cfg_start_step.
- `arst_n` low mid-sweep → all outputs 0 immediately. Mode 1 with start = stop = 5 → tdata = 5 forever.
